seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a one-entry shadow load buffer.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading-zero digits 3..1.
module seg_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        blank,
  output logic [3:0]  nibble,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);

  localparam int              CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DIG_OFF  = DIG_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  typedef enum logic [1:0] {
    S_OFF,
    S_GAP,
    S_SHOW
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic [15:0]      disp, disp_n;
  logic [15:0]      shadow, shadow_n;
  logic             pending, pending_n;
  logic [3:0]       nibble_n;
  logic [3:0]       dig_sel_n;
  logic             lz_dark;
  logic             accept;
  logic             terminal;
  logic             wrap;

  assign load_ready = !pending;
  assign accept     = load_valid && load_ready;
  assign terminal   = (cnt == CNT_LAST);
  assign wrap       = (state == S_SHOW) && terminal && (idx == 2'd3);
  assign frame_done = wrap;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin : next_state
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    disp_n    = disp;
    shadow_n  = shadow;
    pending_n = pending;

    case (state)
      S_OFF: begin
        cnt_n = '0;
        idx_n = 2'd0;
        if (accept) begin
          disp_n  = load_data;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        cnt_n   = cnt + CNT_W'(1);
        state_n = S_SHOW;
      end
      S_SHOW: begin
        if (terminal) begin
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
          state_n = S_GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_OFF;
    endcase

    // Once scanning, loads park in the shadow and only reach disp on a frame wrap.
    if (wrap && pending) begin
      disp_n    = shadow;
      pending_n = 1'b0;
    end else if (accept && (state != S_OFF)) begin
      shadow_n  = load_data;
      pending_n = 1'b1;
    end
  end

  always_comb begin : lead_zero
    lz_dark = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    case (idx_n)
      2'd3:    lz_dark = (disp_n[15:12] == 4'h0);
      2'd2:    lz_dark = (disp_n[15:8] == 8'h00);
      2'd1:    lz_dark = (disp_n[15:4] == 12'h000);
      default: lz_dark = 1'b0;
    endcase
`endif
  end

  // Outputs are registered from the state being entered: nibble leads, dig_sel lights a cycle later.
  always_comb begin : next_outputs
    nibble_n  = 4'h0;
    dig_sel_n = DIG_OFF;
    if (state_n != S_OFF) begin
      nibble_n = disp_n[{idx_n, 2'b00} +: 4];
    end
    if ((state_n == S_SHOW) && !blank && !lz_dark) begin
      dig_sel_n = DIG_ACTIVE_LOW ? ~(4'b0001 << idx_n) : (4'b0001 << idx_n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_OFF;
      cnt     <= '0;
      idx     <= 2'd0;
      // NOTE: the display and shadow registers are cleared too, so a stale value never reappears after reset.
      disp    <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      nibble  <= 4'h0;
      dig_sel <= DIG_OFF;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      disp    <= disp_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      nibble  <= nibble_n;
      dig_sel <= dig_sel_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV = 4, active-low digit enables).
// Expected per-cycle outputs are queued when a load is driven and popped on every falling edge.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam logic [3:0][3:0] DS_ALL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0][3:0] DS_DARK = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [3:0][3:0] DS_0003 = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
  localparam logic [3:0][3:0] DS_00F0 = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
`else
  localparam logic [3:0][3:0] DS_0003 = DS_ALL;
  localparam logic [3:0][3:0] DS_00F0 = DS_ALL;
`endif

  typedef struct {
    logic [15:0]     data;
    logic            blank;
    logic [3:0][3:0] ds;
  } vec_t;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] ds;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        blank;
  logic [3:0]  nibble;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t tbl[6];

  seg_scan_ctrl #(
    .SCAN_DIV      (SCAN_DIV),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .blank     (blank),
    .nibble    (nibble),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // One frame of expected outputs: a dark GAP cycle then SCAN_DIV-1 SHOW cycles per digit.
  task automatic push_frame(input logic [15:0] data, input logic [3:0][3:0] ds);
    for (int d = 0; d < 4; d++) begin
      exp_q.push_back(exp_t'{nib: data[4*d +: 4], ds: 4'b1111, fd: 1'b0});
      for (int s = 1; s < SCAN_DIV; s++) begin
        exp_q.push_back(exp_t'{nib: data[4*d +: 4], ds: ds[d], fd: (d == 3) && (s == SCAN_DIV - 1)});
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: got no expected entry, required one per cycle", $time);
    end else begin
      e = exp_q.pop_front();
      check("nibble", 16'(nibble), 16'(e.nib));
      check("dig_sel", 16'(dig_sel), 16'(e.ds));
      check("frame_done", 16'(frame_done), 16'(e.fd));
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank      = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_load_ready", 16'(load_ready), 16'h1);
    check("rst_nibble", 16'(nibble), 16'h0);
    check("rst_dig_sel", 16'(dig_sel), 16'hF);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("off_nibble", 16'(nibble), 16'h0);
    check("off_dig_sel", 16'(dig_sel), 16'hF);
    check("off_load_ready", 16'(load_ready), 16'h1);
  endtask

  task automatic drive_load(input logic [15:0] data);
    load_data  = data;
    load_valid = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    blank      = 1'b0;

    tbl[0] = '{16'h12AF, 1'b0, DS_ALL};
    tbl[1] = '{16'h0003, 1'b0, DS_0003};
    tbl[2] = '{16'h00F0, 1'b0, DS_00F0};
    tbl[3] = '{16'h8000, 1'b0, DS_ALL};
    tbl[4] = '{16'h0000, 1'b0, DS_0003};
    tbl[5] = '{16'h5A5A, 1'b1, DS_DARK};

    // Table vectors: reset, load from OFF, then two complete frames.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive_load(tbl[i].data);
      blank = tbl[i].blank;
      push_frame(tbl[i].data, tbl[i].ds);
      push_frame(tbl[i].data, tbl[i].ds);
      tick();
      load_valid = 1'b0;
      repeat (2 * FRAME - 1) tick();
    end

    // Mid-frame load, then a held second load while the shadow is full.
    do_reset();
    drive_load(16'h12AF);
    push_frame(16'h12AF, DS_ALL);
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    check("midload_ready_before", 16'(load_ready), 16'h1);
    drive_load(16'h0003);
    push_frame(16'h0003, DS_0003);
    tick();
    load_data = 16'h5555;
    for (int c = 0; c < 10; c++) begin
      check("held_load_ready", 16'(load_ready), 16'h0);
      tick();
    end
    check("wrap_load_ready", 16'(load_ready), 16'h0);
    load_valid = 1'b0;
    push_frame(16'h0003, DS_0003);
    tick();
    check("after_wrap_ready", 16'(load_ready), 16'h1);
    repeat (2 * FRAME - 1) tick();

    // Load accepted in the wrap cycle itself must wait a whole frame.
    do_reset();
    drive_load(16'h12AF);
    push_frame(16'h12AF, DS_ALL);
    push_frame(16'h12AF, DS_ALL);
    tick();
    load_valid = 1'b0;
    repeat (FRAME - 1) tick();
    check("wrapcycle_ready", 16'(load_ready), 16'h1);
    drive_load(16'h0003);
    push_frame(16'h0003, DS_0003);
    tick();
    load_valid = 1'b0;
    check("wrapcycle_pending", 16'(load_ready), 16'h0);
    repeat (2 * FRAME - 1) tick();

    // Reset during a digit-2 SHOW cycle with a pending load.
    do_reset();
    drive_load(16'h12AF);
    push_frame(16'h12AF, DS_ALL);
    tick();
    load_valid = 1'b0;
    repeat (2) tick();
    drive_load(16'h0003);
    tick();
    load_valid = 1'b0;
    check("pending_ready", 16'(load_ready), 16'h0);
    repeat (6) tick();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_load_ready", 16'(load_ready), 16'h1);
    check("midrst_nibble", 16'(nibble), 16'h0);
    check("midrst_dig_sel", 16'(dig_sel), 16'hF);
    check("midrst_frame_done", 16'(frame_done), 16'h0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("postrst_frame_done", 16'(frame_done), 16'h0);
      check("postrst_dig_sel", 16'(dig_sel), 16'hF);
    end
    drive_load(16'h00F0);
    push_frame(16'h00F0, DS_00F0);
    push_frame(16'h00F0, DS_00F0);
    tick();
    load_valid = 1'b0;
    repeat (2 * FRAME - 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
